// File: rtl/dso_pkg.sv
// dso_pkg: shared state, mode and slope encodings for the scope acquisition path
package dso_pkg;
  localparam int SAMPLE_W_DEF = 12;
  localparam int ADDR_W_DEF = 15;
  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POSTFILL, HOLD} cap_state_t;
  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;
endpackage

// File: rtl/capture_ctrl_trig_detect.sv
// trig_detect: level crossing detector comparing each valid sample against the previous one
module trig_detect import dso_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                en,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  output logic                hit
);
  logic [SAMPLE_W-1:0] prev;
  logic prev_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev <= '0;
      prev_valid <= 1'b0;
    end else if (clr) prev_valid <= 1'b0;
    else if (en && sample_valid) begin
      prev <= sample_in;
      prev_valid <= 1'b1;
    end
  always_comb
    hit = en && sample_valid && prev_valid && (trig_slope == SLOPE_RISE ?
          prev < trig_level && sample_in >= trig_level :
          prev > trig_level && sample_in <= trig_level);
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: pre/post-trigger ring-buffer capture sequencer feeding sample RAM port A
module capture_ctrl import dso_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CAPTURE_LEN = 640,
  parameter int PRETRIG = 320,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic [1:0]          mode,
  input  logic                arm,
  input  logic                frame_done,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic [ADDR_W-1:0]   base_addr,
  output logic                frame_ready,
  output logic                triggered
);
  localparam int POST = CAPTURE_LEN - PRETRIG;
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] PRE_A = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] POST_A = ADDR_W'(POST);
  localparam logic [TW-1:0] TO_T = TW'(AUTO_TIMEOUT);
  cap_state_t state;
  logic [ADDR_W-1:0] wptr, trig_addr, pre_cnt, post_cnt;
  logic [TW-1:0] to_cnt;
  logic hit, take, real_hit, forced, restart;
  trig_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state == IDLE || state == HOLD),
    .en(state == PREFILL || state == WAIT_TRIG),
    .sample_valid(sample_valid),
    .sample_in(sample_in),
    .trig_level(trig_level),
    .trig_slope(trig_slope),
    .hit(hit)
  );
  always_comb begin
    take = sample_valid && (state == PREFILL || state == WAIT_TRIG || state == POSTFILL);
    real_hit = hit && state == WAIT_TRIG;
    forced = state == WAIT_TRIG && sample_valid && mode == MODE_AUTO && to_cnt == TO_T;
    restart = state == IDLE ? (mode != MODE_SINGLE || arm) :
              state == HOLD && (arm || (frame_done && mode != MODE_SINGLE));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      wptr <= '0;
      trig_addr <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      to_cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      base_addr <= '0;
      frame_ready <= 1'b0;
      triggered <= 1'b0;
    end else begin
      wr_en <= take;
      if (take) begin
        wr_addr <= wptr;
        wr_data <= sample_in;
        wptr <= wptr + ADDR_W'(1);
      end
      case (state)
        IDLE, HOLD:
          if (restart) begin
            state <= PREFILL;
            frame_ready <= 1'b0;
            pre_cnt <= '0;
            post_cnt <= '0;
            to_cnt <= '0;
          end
        PREFILL:
          if (sample_valid) begin
            pre_cnt <= pre_cnt + ADDR_W'(1);
            if (pre_cnt + ADDR_W'(1) == PRE_A) state <= WAIT_TRIG;
          end
        WAIT_TRIG:
          if (real_hit || forced) begin
            trig_addr <= wptr;
            triggered <= real_hit;
            post_cnt <= ADDR_W'(1);
            if (POST == 1) begin
              state <= HOLD;
              frame_ready <= 1'b1;
              base_addr <= wptr - PRE_A;
            end else state <= POSTFILL;
          end else if (sample_valid && to_cnt != TO_T) to_cnt <= to_cnt + TW'(1);
        POSTFILL:
          if (sample_valid) begin
            post_cnt <= post_cnt + ADDR_W'(1);
            if (post_cnt + ADDR_W'(1) == POST_A) begin
              state <= HOLD;
              frame_ready <= 1'b1;
              base_addr <= trig_addr - PRE_A;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized bench checking capture_ctrl against a record-level model of the capture rules
module tb_capture_ctrl;
  import dso_pkg::*;
  localparam int SW = 12, AW = 15, CL = 640, PT = 320, TO = 4096, POST = CL - PT, DEPTH = 1 << AW;
  logic clk = 1'b0, reset_n = 1'b0, sample_valid = 1'b0, trig_slope = 1'b0, arm = 1'b0, frame_done = 1'b0;
  logic [SW-1:0] sample_in = '0, trig_level = 12'd2048;
  logic [1:0] mode = MODE_NORMAL;
  logic wr_en, frame_ready, triggered;
  logic [AW-1:0] wr_addr, base_addr;
  logic [SW-1:0] wr_data;
  int total = 0, bad = 0, exp_wptr = 0, cap_start = 0, exp_base = 0, wraps = 0;
  logic [SW-1:0] sq[$];
  int wa[$], wd[$];
  always #10 clk = ~clk;
  capture_ctrl #(.SAMPLE_W(SW), .ADDR_W(AW), .CAPTURE_LEN(CL), .PRETRIG(PT), .AUTO_TIMEOUT(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .trig_level(trig_level),
    .trig_slope(trig_slope),
    .mode(mode),
    .arm(arm),
    .frame_done(frame_done),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .base_addr(base_addr),
    .frame_ready(frame_ready),
    .triggered(triggered)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask
  task automatic obs();
    @(negedge clk);
    if (wr_en === 1'b1) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
    end
  endtask
  task automatic drv(input logic v, input logic [SW-1:0] d, input logic a, input logic f);
    sample_valid = v;
    sample_in = d;
    arm = a;
    frame_done = f;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " wr_en"}, wr_en, 0);
    chk({tag, " wr_addr"}, wr_addr, 0);
    chk({tag, " wr_data"}, wr_data, 0);
    chk({tag, " base_addr"}, base_addr, 0);
    chk({tag, " frame_ready"}, frame_ready, 0);
    chk({tag, " triggered"}, triggered, 0);
  endtask
  // 0: ramp reaching 2048 at the first waiting sample, 1: sine around 1000, 2: constant 100, 3: random step at p
  function automatic logic [SW-1:0] gen(input int kind, input int i, input int p);
    real s;
    s = 1000.0 + 900.0 * $sin(6.283185307179586 * real'(i - 20) / 50.0);
    case (kind)
      0: return SW'((1728 + i) % 4096);
      1: return SW'($rtoi(s + 0.5));
      2: return SW'(100);
      default: return i < p ? SW'($urandom_range(0, 2047)) : SW'($urandom_range(2048, 4095));
    endcase
  endfunction
  task automatic capture(input string tag, input int kind, input int p, input int glo, input int ghi,
                         input logic slope, input logic [SW-1:0] lvl, input logic is_auto);
    int t, n, gap, cyc, bad_i;
    logic real_t;
    logic [SW-1:0] d;
    sq.delete();
    wa.delete();
    wd.delete();
    cap_start = exp_wptr;
    gap = 0;
    cyc = 0;
    forever begin
      obs();
      if (frame_ready === 1'b1 || cyc > 20000) break;
      if (gap > 0) begin
        drv(0, '0, 0, 0);
        gap--;
      end else begin
        d = gen(kind, sq.size(), p);
        sq.push_back(d);
        drv(1, d, 0, 0);
        gap = int'($urandom_range(glo, ghi));
      end
      cyc++;
    end
    drv(0, '0, 0, 0);
    t = -1;
    real_t = 1'b0;
    for (int k = PT; k < sq.size() && t < 0; k++)
      if (slope ? (sq[k-1] > lvl && sq[k] <= lvl) : (sq[k-1] < lvl && sq[k] >= lvl)) begin
        t = k;
        real_t = 1'b1;
      end else if (is_auto && k - PT == TO) t = k;
    n = t < 0 ? -1 : t + POST;
    exp_base = (cap_start + t - PT + DEPTH) % DEPTH;
    chk({tag, " ready"}, frame_ready, 1);
    chk({tag, " writes"}, wa.size(), n);
    chk({tag, " samples used"}, sq.size(), n);
    chk({tag, " base"}, base_addr, exp_base);
    chk({tag, " triggered"}, triggered, real_t);
    bad_i = -1;
    for (int i = 0; i < wa.size() && i < sq.size(); i++) begin
      if (bad_i < 0 && (wa[i] != (cap_start + i) % DEPTH || wd[i] != int'(sq[i]))) bad_i = i;
      if (i > 0 && wa[i-1] == DEPTH - 1 && wa[i] == 0) wraps++;
    end
    chk({tag, " first bad write"}, bad_i, -1);
    if (n > 0) exp_wptr = (cap_start + n) % DEPTH;
  endtask
  task automatic hold(input string tag, input int cycles);
    int unstable;
    unstable = 0;
    wa.delete();
    for (int k = 0; k < cycles; k++) begin
      drv(1'($urandom_range(0, 1)), SW'($urandom_range(0, 4095)), 0, 0);
      obs();
      if (frame_ready !== 1'b1 || base_addr !== AW'(exp_base)) unstable++;
    end
    drv(0, '0, 0, 0);
    chk({tag, " hold writes"}, wa.size(), 0);
    chk({tag, " hold stable"}, unstable, 0);
  endtask
  task automatic leave_hold(input string tag, input logic a, input logic f);
    drv(0, '0, a, f);
    obs();
    chk({tag, " ready drop"}, frame_ready, 0);
    drv(0, '0, 0, 0);
  endtask
  initial begin
    int r;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b1;
    capture("ramp", 0, 0, 3, 3, SLOPE_RISE, 2048, 0);
    chk("ramp trig value", wd.size() > PT ? wd[PT] : -1, 2048);
    hold("ramp", 20);
    trig_slope = SLOPE_FALL;
    trig_level = 12'd1000;
    leave_hold("ramp", 0, 1);
    capture("sine", 1, 0, 0, 2, SLOPE_FALL, 1000, 0);
    chk("sine downward base", base_addr, (cap_start + 25) % DEPTH);
    hold("sine", 8);
    mode = MODE_AUTO;
    trig_slope = SLOPE_RISE;
    trig_level = 12'd2048;
    leave_hold("sine", 0, 1);
    capture("auto", 2, 0, 0, 0, SLOPE_RISE, 2048, 1);
    chk("auto base", base_addr, (cap_start + TO) % DEPTH);
    chk("auto forced", triggered, 0);
    hold("auto", 8);
    mode = MODE_NORMAL;
    leave_hold("auto", 0, 1);
    r = 0;
    while (exp_wptr + 2 * CL < DEPTH && r < 60 && bad == 0) begin
      capture("fill", 3, PT, 0, 0, SLOPE_RISE, 2048, 0);
      leave_hold("fill", 0, 1);
      r++;
    end
    wraps = 0;
    capture("wrap", 3, DEPTH - exp_wptr + 10, 0, 0, SLOPE_RISE, 2048, 0);
    chk("wrap seen", wraps, 1);
    chk("wrap base", base_addr, DEPTH + 10 - PT);
    hold("wrap", 8);
    mode = MODE_SINGLE;
    drv(0, '0, 0, 1);
    obs();
    drv(0, '0, 0, 0);
    hold("single frame_done", 10);
    leave_hold("single arm+frame_done", 1, 1);
    capture("single", 3, PT + 5, 0, 1, SLOPE_RISE, 2048, 0);
    hold("single", 5);
    leave_hold("single rearm", 1, 0);
    r = 0;
    for (int i = 0; i < PT + 100; i++) begin
      obs();
      if (frame_ready !== 1'b0) r++;
      drv(1, gen(3, i, PT), 0, 0);
    end
    #3 reset_n = 1'b0;
    #1;
    chk_reset("async reset");
    chk("no partial ready", r, 0);
    exp_wptr = 0;
    drv(0, '0, 0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wa.delete();
    r = 0;
    for (int i = 0; i < 40; i++) begin
      drv(1, SW'($urandom_range(0, 4095)), 0, 0);
      obs();
      if (frame_ready !== 1'b0) r++;
    end
    chk("single idle writes", wa.size(), 0);
    chk("single idle ready", r, 0);
    drv(0, '0, 1, 0);
    obs();
    drv(0, '0, 0, 0);
    capture("single armed", 3, PT + 3, 0, 3, SLOPE_RISE, 2048, 0);
    hold("single armed", 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Acquisition sequencer for the scope's sample buffer. Sits between the ADC channel output and port A of the dual-port sample RAM. It runs a pre-trigger / trigger / post-trigger capture into a circular buffer, then freezes the buffer and hands the display a stable record start address until the display finishes a frame. Supports auto, normal and single-shot trigger modes with rising or falling level triggering.

## Interface
Parameters:
- SAMPLE_W, 12: sample width.
- ADDR_W, 15: RAM address width; the ring buffer is 2^ADDR_W deep.
- CAPTURE_LEN, 640: samples per displayed record.
- PRETRIG, 320: samples kept before the trigger sample. Constraint: 1 ≤ PRETRIG < CAPTURE_LEN ≤ 2^ADDR_W.
- AUTO_TIMEOUT, 4096: number of WAIT_TRIG samples after which auto mode forces a trigger.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- sample_in  in  SAMPLE_W  ADC conversion result.
- sample_valid  in  1  one-cycle strobe; sample_in is a new conversion.
- trig_level  in  SAMPLE_W  trigger threshold (unsigned).
- trig_slope  in  1  0 = rising, 1 = falling.
- mode  in  2  00 = auto, 01 = normal, 10 = single, 11 = treated as normal.
- arm  in  1  pulse; starts a single-shot capture.
- frame_done  in  1  pulse from the display at end of frame readout.
- wr_en  out  1  RAM port A write enable.
- wr_addr  out  ADDR_W  RAM port A address.
- wr_data  out  SAMPLE_W  RAM port A data.
- base_addr  out  ADDR_W  address of the first sample of the frozen record.
- frame_ready  out  1  buffer frozen; base_addr valid.
- triggered  out  1  last record came from a real trigger event (0 if forced by the auto timeout).

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POSTFILL, HOLD.
- **IDLE**
  - mode ≠ single: go to PREFILL next cycle.
  - mode = single: wait for arm.
- **PREFILL**
  - Each valid sample is written; pre_cnt increments.
  - After PRETRIG samples, go to WAIT_TRIG.
  - prev_valid is cleared on entry.
- **WAIT_TRIG**
  - Each valid sample is written (ring overwrite) and compared against prev.
  - Rising trigger: prev < trig_level and cur ≥ trig_level.
  - Falling trigger: prev > trig_level and cur ≤ trig_level.
  - No trigger is possible without prev_valid.
  - The trigger sample is written at trig_addr and counts as post sample 1. Go to POSTFILL, or to HOLD if CAPTURE_LEN − PRETRIG = 1.
  - Auto mode: after AUTO_TIMEOUT non-triggering samples, the next valid sample is a forced trigger with triggered = 0.
  - A real trigger sets triggered = 1.
- **POSTFILL**
  - Write samples until CAPTURE_LEN − PRETRIG post samples (including the trigger sample) are written, then go to HOLD.
- Record start: base_addr = (trig_addr − PRETRIG) mod 2^ADDR_W. It is loaded on entry to HOLD only.
- **HOLD**
  - frame_ready = 1; no writes; sample_valid is ignored.
  - On frame_done with mode ≠ single: go to PREFILL.
  - With mode = single: stay in HOLD (frame kept on screen) until arm, then go to PREFILL.
  - arm and frame_done in the same cycle: arm wins.
- arm outside IDLE and HOLD is ignored.
- mode is sampled only at IDLE/HOLD decisions and at the auto-timeout check. Changing mode mid-capture does not abort the capture.
- Write pointer: ADDR_W bits, increments once per write, wraps 2^ADDR_W − 1 → 0.
- All counter arithmetic is unsigned and wraps modulo 2^ADDR_W. The timeout counter saturates.

## Timing
- All outputs are registered.
- Write latency: a sample_valid in cycle N in PREFILL, WAIT_TRIG or POSTFILL produces, in cycle N+1, wr_en = 1, wr_data = sample_in(N) and wr_addr = wptr. wptr then increments.
- wr_en is high for exactly one cycle per accepted sample.
- frame_ready rises in the same cycle as the last post-trigger wr_en. base_addr is valid in that cycle.
- frame_ready falls the cycle after the leaving event (frame_done, or arm in single mode).
- Back-to-back sample_valid (every cycle) must be supported with no dropped samples.
- Reset values: state = IDLE; wr_en = 0; wr_addr = 0; wr_data = 0; base_addr = 0; frame_ready = 0; triggered = 0; wptr = 0; all counters = 0; prev_valid = 0.
- Reset asserted mid-capture aborts immediately. No partial record is flagged ready.

## Structure
- Package dso_pkg holds:
  - the state enum;
  - mode encodings (MODE_AUTO, MODE_NORMAL, MODE_SINGLE);
  - the slope encoding;
  - SAMPLE_W and ADDR_W defaults.
- Sub-module trig_detect holds the prev register, prev_valid and the slope/level comparator. Outputs: a one-cycle hit, qualified by sample_valid.
- capture_ctrl holds the FSM, the counters, wptr and the output registers.

## Test plan
- Normal mode, rising, level 2048, ramp 0..4095 with one sample per 4 clk:
  - trigger at the sample with value 2048;
  - base_addr = trig_addr − 320;
  - exactly 640 writes from PREFILL start to frame_ready... then no writes in HOLD.
- Falling slope, level 1000, sine input:
  - triggers only on the downward crossing;
  - a sample equal to 1000 on the way up does not trigger.
- Auto mode, constant input 100, level 2048:
  - after 320 prefill samples plus 4096 waiting samples, the next sample forces a trigger;
  - frame_ready = 1 and triggered = 0.
- Wrap-around: preload wptr near 32760 via a run of captures:
  - wr_addr wraps 32767 → 0;
  - base_addr computed modulo 2^15.
- Single mode:
  - no capture before arm;
  - after capture, frame_done does not restart;
  - arm with simultaneous frame_done in HOLD restarts PREFILL and drops frame_ready the next cycle.
- Reset in POSTFILL with sample_valid every cycle:
  - all outputs return to their reset values asynchronously;
  - frame_ready never pulses.
